// File: rtl/ir_pkg.sv
// Shared types and per-car timing tables for the IR packet generator.
// Region lengths are in carrier periods; half_period is in clock cycles.
package ir_pkg;

    localparam int NUM_CARS  = 4;
    localparam int CMD_RIGHT = 0;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_BACK  = 2;
    localparam int CMD_FWD   = 3;

    typedef enum logic [1:0] {BLUE, YELLOW, GREEN, RED} car_e;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_GAP, S_SELECT, S_RIGHT, S_LEFT, S_BACK, S_FWD
    } pkt_state_e;

    typedef struct packed {
        logic [15:0] half_period;
        logic [7:0]  start;
        logic [7:0]  gap;
        logic [7:0]  select;
        logic [7:0]  assert_n;
        logic [7:0]  deassert_n;
    } car_timing_t;

    typedef car_timing_t [0:NUM_CARS-1] car_table_t;

    localparam int unsigned CAR_CARRIER_HZ [NUM_CARS] = '{36_000, 40_000, 37_500, 36_000};

    // half_period here assumes a 100 MHz clock; scale_timing recomputes it for the real clock.
    localparam car_table_t CAR_TIMING = '{
        '{16'd1389, 8'd191, 8'd25, 8'd47, 8'd47, 8'd22},
        '{16'd1250, 8'd88,  8'd40, 8'd22, 8'd44, 8'd22},
        '{16'd1333, 8'd88,  8'd40, 8'd44, 8'd44, 8'd22},
        '{16'd1389, 8'd192, 8'd24, 8'd24, 8'd48, 8'd24}
    };

    function automatic car_table_t scale_timing(input int unsigned clk_hz);
        car_table_t t;
        t = CAR_TIMING;
        for (int i = 0; i < NUM_CARS; i++) begin
            t[i].half_period = 16'(clk_hz / (2 * CAR_CARRIER_HZ[i]));
        end
        return t;
    endfunction

    function automatic int unsigned max_half(input car_table_t t);
        int unsigned m;
        m = 0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (32'(t[i].half_period) > m) begin
                m = 32'(t[i].half_period);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier: high for half_last+1 cycles, then low for the same,
// with a pulse on the last cycle of each full period.
module ir_carrier_gen #(
    parameter int HW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic [HW-1:0] half_last,
    output logic          carrier,
    output logic          period_done
);

    logic [HW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Restart puts the carrier at the start of a high phase on the next cycle.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        level_d = level_q;
        if (restart) begin
            cnt_d   = '0;
            level_d = 1'b1;
        end else if (cnt_q == half_last) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign carrier     = level_q;
    assign period_done = !level_q && (cnt_q == half_last);

endmodule

// File: rtl/ir_packet_generator.sv
// Periodically sends a car-specific modulated IR packet carrying the latched
// drive command: START, SELECT and four direction bursts separated by gaps.
module ir_packet_generator
    import ir_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ               = 100_000_000,
    parameter int unsigned TRANSMISSION_FREQUENCY_HZ = 10,
    parameter int unsigned CAR_COUNT                 = 4,
    parameter int unsigned CMD_LEN                   = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [CMD_LEN-1:0]           COMMAND,
    input  logic [$clog2(CAR_COUNT)-1:0] CAR_SWITCHES,
    output logic [$clog2(CAR_COUNT)-1:0] LEDS,
    output logic                         IR_LED,
    output logic                         BUSY
);

    localparam int unsigned SEND_PERIOD = CLK_FREQ_HZ / TRANSMISSION_FREQUENCY_HZ;
    localparam int          SW          = (SEND_PERIOD > 1) ? $clog2(SEND_PERIOD) : 1;
    localparam logic [SW-1:0] SEND_LAST = SW'(SEND_PERIOD - 1);
    localparam int          CS          = $clog2(CAR_COUNT);
    localparam car_table_t  TIMING      = scale_timing(CLK_FREQ_HZ);
    localparam int unsigned MAX_HALF    = max_half(TIMING);
    localparam int          HW          = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

    logic [SW-1:0]      send_cnt_q, send_cnt_d;
    logic               trigger;
    pkt_state_e         state_q, state_d;
    pkt_state_e         next_burst_q, next_burst_d;
    logic [7:0]         per_cnt_q, per_cnt_d;
    logic [CMD_LEN-1:0] cmd_q, cmd_d;
    logic [CS-1:0]      car_q, car_d;
    logic [7:0]         region_len;
    logic               restart;
    logic               carrier;
    logic               period_done;
    logic [HW-1:0]      half_last;

    assign trigger    = (send_cnt_q == SEND_LAST);
    assign send_cnt_d = trigger ? '0 : send_cnt_q + 1'b1;
    assign half_last  = HW'(TIMING[car_q].half_period - 16'd1);

    always_comb begin
        region_len = 8'd1;
        case (state_q)
            S_START:  region_len = TIMING[car_q].start;
            S_GAP:    region_len = TIMING[car_q].gap;
            S_SELECT: region_len = TIMING[car_q].select;
            S_RIGHT:  region_len = cmd_q[CMD_RIGHT] ? TIMING[car_q].assert_n : TIMING[car_q].deassert_n;
            S_LEFT:   region_len = cmd_q[CMD_LEFT]  ? TIMING[car_q].assert_n : TIMING[car_q].deassert_n;
            S_BACK:   region_len = cmd_q[CMD_BACK]  ? TIMING[car_q].assert_n : TIMING[car_q].deassert_n;
            S_FWD:    region_len = cmd_q[CMD_FWD]   ? TIMING[car_q].assert_n : TIMING[car_q].deassert_n;
            default:  region_len = 8'd1;
        endcase
    end

    // The shared GAP state remembers which burst follows it in next_burst_q.
    always_comb begin
        state_d      = state_q;
        next_burst_d = next_burst_q;
        per_cnt_d    = per_cnt_q;
        cmd_d        = cmd_q;
        car_d        = car_q;
        restart      = 1'b0;
        if (state_q == S_IDLE) begin
            if (trigger) begin
                state_d   = S_START;
                cmd_d     = COMMAND;
                car_d     = CAR_SWITCHES;
                per_cnt_d = '0;
                restart   = 1'b1;
            end
        end else if (period_done) begin
            if (per_cnt_q == region_len - 8'd1) begin
                per_cnt_d = '0;
                case (state_q)
                    S_START:  begin state_d = S_GAP; next_burst_d = S_SELECT; end
                    S_SELECT: begin state_d = S_GAP; next_burst_d = S_RIGHT;  end
                    S_RIGHT:  begin state_d = S_GAP; next_burst_d = S_LEFT;   end
                    S_LEFT:   begin state_d = S_GAP; next_burst_d = S_BACK;   end
                    S_BACK:   begin state_d = S_GAP; next_burst_d = S_FWD;    end
                    S_GAP:    state_d = next_burst_q;
                    default:  state_d = S_IDLE;
                endcase
            end else begin
                per_cnt_d = per_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            send_cnt_q   <= '0;
            state_q      <= S_IDLE;
            next_burst_q <= S_IDLE;
            per_cnt_q    <= '0;
            cmd_q        <= '0;
            car_q        <= '0;
        end else begin
            send_cnt_q   <= send_cnt_d;
            state_q      <= state_d;
            next_burst_q <= next_burst_d;
            per_cnt_q    <= per_cnt_d;
            cmd_q        <= cmd_d;
            car_q        <= car_d;
        end
    end

    ir_carrier_gen #(
        .HW(HW)
    ) u_carrier (
        .clk         (CLK),
        .reset       (RESET),
        .restart     (restart),
        .half_last   (half_last),
        .carrier     (carrier),
        .period_done (period_done)
    );

    assign BUSY   = (state_q != S_IDLE);
    assign LEDS   = car_q;
    assign IR_LED = carrier && (state_q != S_IDLE) && (state_q != S_GAP);

endmodule
